// File: rtl/rvm_mem_bridge_if.sv
// rvm_mem_bridge_if: req/gnt/rvalid system-bus port of the core memory bridge.
// The bridge side uses the master modport, the bus/memory side uses slave.
`timescale 1ns/1ps
interface rvm_mem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/rvm_mem_bridge.sv
// rvm_mem_bridge: converts the core's hold-until-unstalled request
// (core_c_en/core_stall) into a single outstanding req/gnt/rvalid bus
// transaction and returns registered read data plus a bus/alignment error.
// Optional feature: define RVM_MEM_TIMEOUT_EN to enable the REQ/WAIT
// timeout and the FLUSH state that drains a late response.
`timescale 1ns/1ps
module rvm_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      core_addr,
    input  logic [31:0]      core_wdata,
    input  logic             core_c_en,
    input  logic             core_w_en,
    input  logic [3:0]       core_b_en,
    output logic [31:0]      core_rdata,
    output logic             core_error,
    output logic             core_stall,
    rvm_mem_bridge_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rvm_mem_bridge: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FLUSH} state_t;

    state_t      state, state_nxt;
    logic        req_nxt, we_nxt;
    logic [3:0]  be_nxt;
    logic [31:0] addr_nxt, wdata_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic        err_q, err_nxt;

`ifdef RVM_MEM_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt, cnt_nxt;
    logic       flush_q, flush_nxt;
`endif

    assign core_stall = core_c_en & (state != DONE);
    assign core_rdata = rdata_q;
    assign core_error = err_q;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_be    <= '0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
`ifdef RVM_MEM_TIMEOUT_EN
            cnt           <= '0;
            flush_q       <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            bus.bus_req   <= req_nxt;
            bus.bus_we    <= we_nxt;
            bus.bus_be    <= be_nxt;
            bus.bus_addr  <= addr_nxt;
            bus.bus_wdata <= wdata_nxt;
            rdata_q       <= rdata_nxt;
            err_q         <= err_nxt;
`ifdef RVM_MEM_TIMEOUT_EN
            cnt           <= cnt_nxt;
            flush_q       <= flush_nxt;
`endif
        end
    end

    // Next-state and next-register logic; everything holds unless changed.
    always_comb begin
        state_nxt = state;
        req_nxt   = bus.bus_req;
        we_nxt    = bus.bus_we;
        be_nxt    = bus.bus_be;
        addr_nxt  = bus.bus_addr;
        wdata_nxt = bus.bus_wdata;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
`ifdef RVM_MEM_TIMEOUT_EN
        cnt_nxt   = cnt;
        flush_nxt = flush_q;
`endif
        case (state)
            IDLE: begin
                if (core_c_en) begin
                    if (core_addr[1:0] != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        req_nxt   = 1'b1;
                        we_nxt    = core_w_en;
                        be_nxt    = core_b_en;
                        addr_nxt  = core_addr;
                        wdata_nxt = core_wdata;
                        state_nxt = REQ;
`ifdef RVM_MEM_TIMEOUT_EN
                        cnt_nxt   = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (bus.bus_gnt) begin
                    req_nxt   = 1'b0;
                    state_nxt = WAIT;
`ifdef RVM_MEM_TIMEOUT_EN
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
`endif
                end
            end
            WAIT: begin
                if (bus.bus_rvalid) begin
                    rdata_nxt = bus.bus_we ? '0 : bus.bus_rdata;
                    err_nxt   = bus.bus_err;
                    state_nxt = DONE;
`ifdef RVM_MEM_TIMEOUT_EN
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    flush_nxt = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
`endif
                end
            end
            DONE: begin
                err_nxt   = 1'b0;
                state_nxt = IDLE;
`ifdef RVM_MEM_TIMEOUT_EN
                if (flush_q) begin
                    flush_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = FLUSH;
                end
`endif
            end
            FLUSH: begin
`ifdef RVM_MEM_TIMEOUT_EN
                if (bus.bus_rvalid || cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rvm_mem_bridge.sv
// tb_rvm_mem_bridge: directed bench for rvm_mem_bridge. A per-transaction
// timing model (cycle offsets derived from grant/response delays) feeds the
// expectations checked by one compare process on every falling clock edge.
// The timeout scenario runs only when RVM_MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_rvm_mem_bridge;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_c_en = 1'b0;
    logic        core_w_en = 1'b0;
    logic [3:0]  core_b_en = '0;
    logic [31:0] core_rdata;
    logic        core_error;
    logic        core_stall;

    rvm_mem_bridge_if bus_if ();

    rvm_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_c_en  (core_c_en),
        .core_w_en  (core_w_en),
        .core_b_en  (core_b_en),
        .core_rdata (core_rdata),
        .core_error (core_error),
        .core_stall (core_stall),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expectations for the current cycle, written by the stimulus.
    logic        mon_en = 1'b0;
    logic        exp_stall = 1'b0, exp_req = 1'b0, exp_done = 1'b0;
    logic        exp_err = 1'b0, chk_rdata = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process against the model's per-cycle expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("stall", core_stall, exp_stall);
            chk("bus_req", bus_if.bus_req, exp_req);
            if (exp_req) begin
                chk("bus_addr", bus_if.bus_addr, exp_addr);
                chk("bus_we", bus_if.bus_we, exp_we);
                chk("bus_be", bus_if.bus_be, exp_be);
                chk("bus_wdata", bus_if.bus_wdata, exp_wdata);
            end
            if (exp_done) begin
                chk("error", core_error, exp_err);
                if (chk_rdata) chk("rdata", core_rdata, exp_rdata);
            end
        end
    end

    // One core transaction. g = extra REQ cycles before gnt, r = extra WAIT
    // cycles before rvalid. Cycle 0 is the IDLE cycle that sees core_c_en;
    // the result cycle is 1 for a misaligned address, else 3+g+r.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [3:0] be, input int unsigned g, input int unsigned r,
                       input logic [31:0] resp, input logic rerr);
        logic mis;
        int unsigned done_k;
        mis    = (addr[1:0] != 2'b00);
        done_k = mis ? 1 : 3 + g + r;
        core_addr = addr; core_wdata = wdata; core_w_en = we; core_b_en = be;
        core_c_en = 1'b1;
        exp_addr = addr; exp_wdata = wdata; exp_we = we; exp_be = be;
        exp_rdata = we ? 32'h0 : resp;
        exp_err   = mis | rerr;
        chk_rdata = !mis;
        for (int unsigned k = 0; k <= done_k; k++) begin
            exp_stall = (k != done_k);
            exp_req   = !mis && k >= 1 && k <= 1 + g;
            exp_done  = (k == done_k);
            bus_if.bus_gnt    = !mis && (k == 1 + g);
            bus_if.bus_rvalid = !mis && (k == 2 + g + r);
            bus_if.bus_rdata  = (k == 2 + g + r) ? resp : 32'hBAD0_0000 + k;
            bus_if.bus_err    = (k == 2 + g + r) ? rerr : 1'b1;
            if (k == done_k) begin
                last_rdata = core_rdata;
                last_err   = core_error;
            end
            @(posedge clk); #1;
        end
        core_c_en = 1'b0;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
        @(posedge clk); #1;
    endtask

    // Idle cycle with stray gnt/rvalid that the bridge must ignore.
    task automatic idle_noise();
        bus_if.bus_gnt = 1'b1; bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata = 32'hFFFF_FFFF; bus_if.bus_err = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata = '0; bus_if.bus_err = 1'b0;

        // Reset values; stall follows core_c_en while in IDLE.
        core_c_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_bus_req", bus_if.bus_req, 1'b0);
        chk("rst_bus_we", bus_if.bus_we, 1'b0);
        chk("rst_bus_be", bus_if.bus_be, 4'h0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_error", core_error, 1'b0);
        chk("rst_stall", core_stall, 1'b1);
        core_c_en = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // 1: read, gnt in first REQ cycle, rvalid two cycles later.
        txn(32'h0000_0100, 32'h0, 1'b0, 4'hF, 0, 1, 32'hDEAD_BEEF, 1'b0);
        chk("t1_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("t1_error", last_err, 1'b0);

        // 2: write; writes return zero data.
        txn(32'h0000_0204, 32'h1234_5678, 1'b1, 4'b0011, 1, 0, 32'hCAFE_F00D, 1'b0);
        chk("t2_rdata", last_rdata, 32'h0);
        chk("t2_error", last_err, 1'b0);

        // 3: misaligned read, no bus access.
        txn(32'h0000_0102, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, 1'b0);
        chk("t3_error", last_err, 1'b1);

        idle_noise();

        // 4: bus error, then a clean read clears it.
        txn(32'h0000_0300, 32'h0, 1'b0, 4'hF, 2, 3, 32'h1111_2222, 1'b1);
        chk("t4_error", last_err, 1'b1);
        txn(32'h0000_0304, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0000_0005, 1'b0);
        chk("t4b_rdata", last_rdata, 32'h5);
        chk("t4b_error", last_err, 1'b0);
        txn(32'h0000_0308, 32'hA5A5_5A5A, 1'b1, 4'b1100, 0, 0, 32'h7777_7777, 1'b0);

        // 6: asynchronous reset while in WAIT.
        mon_en = 1'b0;
        core_addr = 32'h0000_0400; core_w_en = 1'b0; core_b_en = 4'hF; core_c_en = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("t6_req", bus_if.bus_req, 1'b0);
        chk("t6_stall", core_stall, 1'b1);
        chk("t6_error", core_error, 1'b0);
        @(posedge clk); #1;
        core_c_en = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h0000_0077; bus_if.bus_err = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_rvalid = 1'b0; bus_if.bus_err = 1'b0;
        chk("t6_late_stall", core_stall, 1'b0);
        chk("t6_late_req", bus_if.bus_req, 1'b0);
        chk("t6_late_rdata", core_rdata, 32'h0);
        chk("t6_late_error", core_error, 1'b0);
        mon_en = 1'b1;
        txn(32'h0000_0408, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0000_ABCD, 1'b0);
        chk("t6_next_rdata", last_rdata, 32'h0000_ABCD);

`ifdef RVM_MEM_TIMEOUT_EN
        // 5a: gnt never arrives; REQ lasts TO cycles, then DONE with error.
        mon_en = 1'b0;
        core_addr = 32'h0000_0500; core_w_en = 1'b0; core_c_en = 1'b1;
        for (int unsigned k = 0; k <= TO + 1; k++) begin
            chk("t5a_stall", core_stall, (k != TO + 1));
            chk("t5a_req", bus_if.bus_req, (k >= 1 && k <= TO));
            if (k == TO + 1) chk("t5a_error", core_error, 1'b1);
            @(posedge clk); #1;
        end
        core_c_en = 1'b0;
        @(posedge clk); #1;

        // 5b: gnt at REQ cycle 3, rvalid never; WAIT times out, then FLUSH.
        core_addr = 32'h0000_0504; core_c_en = 1'b1;
        for (int unsigned k = 0; k <= TO + 4; k++) begin
            bus_if.bus_gnt = (k == 3);
            chk("t5b_stall", core_stall, (k != TO + 4));
            if (k == TO + 4) chk("t5b_error", core_error, 1'b1);
            @(posedge clk); #1;
        end
        bus_if.bus_gnt = 1'b0;
        core_addr = 32'h0000_0508;
        begin
            int unsigned waited;
            waited = 0;
            while (bus_if.bus_req !== 1'b1 && waited < 40) begin
                chk("t5b_flush_stall", core_stall, 1'b1);
                waited++;
                @(posedge clk); #1;
            end
            chk("t5b_flush_len", waited, TO + 1);
        end
        bus_if.bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0;
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h0000_0099;
        @(posedge clk); #1;
        bus_if.bus_rvalid = 1'b0;
        chk("t5b_next_stall", core_stall, 1'b0);
        chk("t5b_next_rdata", core_rdata, 32'h0000_0099);
        chk("t5b_next_error", core_error, 1'b0);
        core_c_en = 1'b0;
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
